// File: rtl/ram_master.sv
// CPU-side load/store initiator for the cpu_ram_if RAM protocol (package rv32ima_pkg included here).
// Optional access counters are enabled by defining RAM_MASTER_STATS_EN.
package rv32ima_pkg;
    typedef enum logic [1:0] {
        RAM_FREE  = 2'd0,
        RAM_ADDR  = 2'd1,
        RAM_DATA  = 2'd2,
        RAM_ERROR = 2'd3
    } ram_state_t;
endpackage

module ram_master #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [2:0]              req_funct3,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [1:0]              ram_width,
    output logic [31:0]             ram_store,
    input  logic [31:0]             ram_load,
    input  rv32ima_pkg::ram_state_t ram_state,
    output logic [31:0]             stat_reads,
    output logic [31:0]             stat_writes,
    output logic [31:0]             stat_errors
);
    import rv32ima_pkg::*;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2:0]         f3_reg, f3_next;
    logic               ram_ren_reg, ram_ren_next;
    logic               ram_wen_reg, ram_wen_next;
    logic [ADDR_W-1:0]  ram_addr_reg, ram_addr_next;
    logic [1:0]         ram_width_reg, ram_width_next;
    logic [31:0]        ram_store_reg, ram_store_next;
    logic               resp_valid_reg, resp_valid_next;
    logic               resp_err_reg, resp_err_next;
    logic [31:0]        resp_rdata_reg, resp_rdata_next;
    logic               accept;
    logic               req_bad;

    function automatic logic [31:0] lane_store(input logic [31:0] wdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [31:0] result;
        case (f3[1:0])
            2'b00:   result = {24'b0, wdata[7:0]}  << {off, 3'b000};
            2'b01:   result = {16'b0, wdata[15:0]} << {off[1], 4'b0000};
            default: result = wdata;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] result;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (f3)
            3'b000:  result = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  result = {24'b0, byte_sh[7:0]};
            3'b001:  result = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  result = {16'b0, half_sh[15:0]};
            3'b010:  result = word;
            default: result = 32'b0;
        endcase
        return result;
    endfunction

    assign req_ready = (state_reg == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Requests that can never be issued to the RAM are answered with an error directly.
    always_comb begin
        case (req_funct3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = req_addr[0];
            3'b010:         req_bad = |req_addr[1:0];
            default:        req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            f3_reg         <= '0;
            ram_ren_reg    <= 1'b0;
            ram_wen_reg    <= 1'b0;
            ram_addr_reg   <= '0;
            ram_width_reg  <= '0;
            ram_store_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            f3_reg         <= f3_next;
            ram_ren_reg    <= ram_ren_next;
            ram_wen_reg    <= ram_wen_next;
            ram_addr_reg   <= ram_addr_next;
            ram_width_reg  <= ram_width_next;
            ram_store_reg  <= ram_store_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? ERR : BUSY;
                end
            end
            BUSY: begin
                if (ram_state == RAM_DATA) begin
                    state_next = DONE;
                end else if (ram_state == RAM_ERROR) begin
                    state_next = ERR;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they line up with it.
    always_comb begin
        cnt_next        = '0;
        f3_next         = f3_reg;
        ram_ren_next    = 1'b0;
        ram_wen_next    = 1'b0;
        ram_addr_next   = ram_addr_reg;
        ram_width_next  = ram_width_reg;
        ram_store_next  = ram_store_reg;
        resp_valid_next = (state_next == DONE) || (state_next == ERR);
        resp_err_next   = (state_next == ERR);
        resp_rdata_next = '0;
        case (state_reg)
            IDLE: begin
                if (accept && !req_bad) begin
                    f3_next        = req_funct3;
                    ram_ren_next   = !req_write;
                    ram_wen_next   = req_write;
                    ram_addr_next  = req_addr;
                    ram_width_next = req_funct3[1:0];
                    ram_store_next = lane_store(req_wdata, req_funct3, req_addr[1:0]);
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (state_next == BUSY) begin
                    ram_ren_next = ram_ren_reg;
                    ram_wen_next = ram_wen_reg;
                end else if (state_next == DONE && ram_ren_reg) begin
                    resp_rdata_next = load_extend(ram_load, f3_reg, ram_addr_reg[1:0]);
                end
            end
            default: ;
        endcase
    end

    assign ram_ren    = ram_ren_reg;
    assign ram_wen    = ram_wen_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_width  = ram_width_reg;
    assign ram_store  = ram_store_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;

`ifdef RAM_MASTER_STATS_EN
    logic [31:0] stat_reads_reg, stat_writes_reg, stat_errors_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads_reg  <= '0;
            stat_writes_reg <= '0;
            stat_errors_reg <= '0;
        end else begin
            if (state_reg == BUSY && state_next == DONE) begin
                if (ram_wen_reg) begin
                    stat_writes_reg <= stat_writes_reg + 32'd1;
                end else begin
                    stat_reads_reg <= stat_reads_reg + 32'd1;
                end
            end
            if (state_next == ERR) begin
                stat_errors_reg <= stat_errors_reg + 32'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_reg;
    assign stat_writes = stat_writes_reg;
    assign stat_errors = stat_errors_reg;
`else
    assign stat_reads  = 32'd0;
    assign stat_writes = 32'd0;
    assign stat_errors = 32'd0;
`endif

endmodule
